// File: rtl/perf_pkg.sv
// Shared register map, counter selectors and CTRL bit positions for the
// retire-side performance monitor.
package perf_pkg;

  localparam logic [31:0] OFF_CTRL     = 32'h00;
  localparam logic [31:0] OFF_CYCLE_LO = 32'h04;
  localparam logic [31:0] OFF_CYCLE_HI = 32'h08;
  localparam logic [31:0] OFF_INSN_LO  = 32'h0C;
  localparam logic [31:0] OFF_INSN_HI  = 32'h10;
  localparam logic [31:0] OFF_CTRL_LO  = 32'h14;
  localparam logic [31:0] OFF_CTRL_HI  = 32'h18;
  localparam logic [31:0] OFF_MISP_LO  = 32'h1C;
  localparam logic [31:0] OFF_MISP_HI  = 32'h20;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  localparam int NUM_CNT = 4;

  typedef enum logic [1:0] {
    SEL_CYCLE = 2'd0,
    SEL_INSN  = 2'd1,
    SEL_CTRL  = 2'd2,
    SEL_MISP  = 2'd3
  } cnt_sel_e;

endpackage

// File: rtl/perf_counter.sv
// One free-running event counter with a HI-half shadow that is captured when
// the LO half is read, so software sees a coherent wide value.
module perf_counter #(
  parameter int unsigned CNT_W = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               clr,
  input  logic               snap,
  output logic [CNT_W-1:0]   value,
  output logic [CNT_W-33:0]  shadow
);

  logic [CNT_W-1:0] cnt;

  // Snapshot takes the pre-increment HI half so it matches the LO just returned.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      shadow <= '0;
    end else if (clr) begin
      cnt    <= '0;
      shadow <= '0;
    end else begin
      if (snap) shadow <= cnt[CNT_W-1:32];
      if (inc)  cnt    <= cnt + CNT_W'(1);
    end
  end

  assign value = cnt;

endmodule

// File: rtl/perf_monitor.sv
// Retire-side debug register stage plus four memory-mapped performance
// counters (cycles, retired, control transfers, mispredictions).
module perf_monitor
  import perf_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int unsigned CNT_W     = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_vld,
  input  logic [31:0] i_wb_pc,
  input  logic        i_wb_is_ctrl,
  input  logic        i_wb_mispred,
  input  logic [31:0] i_lsu_addr,
  input  logic        i_lsu_wren,
  input  logic        i_lsu_rden,
  input  logic [31:0] i_lsu_wdata,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_rvld,
  output logic        o_insn_vld,
  output logic [31:0] o_pc_debug,
  output logic        o_ctrl,
  output logic        o_mispred
);

  logic [31:0]       off;
  logic              hit;
  logic              wr_hit;
  logic              rd_hit;
  logic              wr_ctrl;
  logic              clr;
  logic              en;
  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] snap;
  logic [31:0]       rd_mux;
  logic [CNT_W-1:0]  live [NUM_CNT];
  logic [CNT_W-33:0] shd  [NUM_CNT];

  assign off = i_lsu_addr - BASE_ADDR;
  assign hit = (i_lsu_addr >= BASE_ADDR) && (off <= OFF_MISP_HI) &&
               (i_lsu_addr[1:0] == 2'b00);

  // A simultaneous load and store is a store; the load is dropped.
  assign wr_hit  = hit && i_lsu_wren;
  assign rd_hit  = hit && i_lsu_rden && !i_lsu_wren;
  assign wr_ctrl = wr_hit && (off == OFF_CTRL);
  assign clr     = wr_ctrl && i_lsu_wdata[CTRL_CLR_BIT];

  assign inc[SEL_CYCLE] = en;
  assign inc[SEL_INSN]  = en && i_wb_vld;
  assign inc[SEL_CTRL]  = en && i_wb_vld && i_wb_is_ctrl;
  assign inc[SEL_MISP]  = en && i_wb_vld && i_wb_is_ctrl && i_wb_mispred;

  assign snap[SEL_CYCLE] = rd_hit && (off == OFF_CYCLE_LO);
  assign snap[SEL_INSN]  = rd_hit && (off == OFF_INSN_LO);
  assign snap[SEL_CTRL]  = rd_hit && (off == OFF_CTRL_LO);
  assign snap[SEL_MISP]  = rd_hit && (off == OFF_MISP_LO);

  perf_counter #(.CNT_W(CNT_W)) u_cycle (
    .clk(i_clk), .reset(i_reset), .inc(inc[SEL_CYCLE]), .clr(clr),
    .snap(snap[SEL_CYCLE]), .value(live[SEL_CYCLE]), .shadow(shd[SEL_CYCLE])
  );

  perf_counter #(.CNT_W(CNT_W)) u_insn (
    .clk(i_clk), .reset(i_reset), .inc(inc[SEL_INSN]), .clr(clr),
    .snap(snap[SEL_INSN]), .value(live[SEL_INSN]), .shadow(shd[SEL_INSN])
  );

  perf_counter #(.CNT_W(CNT_W)) u_ctrl (
    .clk(i_clk), .reset(i_reset), .inc(inc[SEL_CTRL]), .clr(clr),
    .snap(snap[SEL_CTRL]), .value(live[SEL_CTRL]), .shadow(shd[SEL_CTRL])
  );

  perf_counter #(.CNT_W(CNT_W)) u_misp (
    .clk(i_clk), .reset(i_reset), .inc(inc[SEL_MISP]), .clr(clr),
    .snap(snap[SEL_MISP]), .value(live[SEL_MISP]), .shadow(shd[SEL_MISP])
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      en <= 1'b1;
    end else if (wr_ctrl) begin
      en <= i_lsu_wdata[CTRL_EN_BIT];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_CTRL:     rd_mux = {31'b0, en};
      OFF_CYCLE_LO: rd_mux = live[SEL_CYCLE][31:0];
      OFF_CYCLE_HI: rd_mux = 32'(shd[SEL_CYCLE]);
      OFF_INSN_LO:  rd_mux = live[SEL_INSN][31:0];
      OFF_INSN_HI:  rd_mux = 32'(shd[SEL_INSN]);
      OFF_CTRL_LO:  rd_mux = live[SEL_CTRL][31:0];
      OFF_CTRL_HI:  rd_mux = 32'(shd[SEL_CTRL]);
      OFF_MISP_LO:  rd_mux = live[SEL_MISP][31:0];
      OFF_MISP_HI:  rd_mux = 32'(shd[SEL_MISP]);
      default:      rd_mux = '0;
    endcase
  end

  // Load data is forced to zero on any non-hit cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_lsu_rdata <= '0;
      o_lsu_rvld  <= 1'b0;
    end else begin
      o_lsu_rdata <= rd_hit ? rd_mux : 32'h0;
      o_lsu_rvld  <= rd_hit;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_insn_vld <= 1'b0;
      o_pc_debug <= '0;
      o_ctrl     <= 1'b0;
      o_mispred  <= 1'b0;
    end else begin
      o_insn_vld <= i_wb_vld;
      o_pc_debug <= i_wb_pc;
      o_ctrl     <= i_wb_vld && i_wb_is_ctrl;
      o_mispred  <= i_wb_vld && i_wb_is_ctrl && i_wb_mispred;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{i_lsu_wdata[31:2],
                         live[SEL_CYCLE][CNT_W-1:32], live[SEL_INSN][CNT_W-1:32],
                         live[SEL_CTRL][CNT_W-1:32],  live[SEL_MISP][CNT_W-1:32]};

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: directed corner sequences, a read table and
// randomized traffic, all checked against a word-level model of the counters.
module tb_perf_monitor;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_vld, wb_ctrl, wb_misp;
  logic [31:0] wb_pc;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_wren, lsu_rden;
  logic [31:0] o_lsu_rdata, o_pc_debug;
  logic        o_lsu_rvld, o_insn_vld, o_ctrl, o_mispred;

  always #5 clk = ~clk;

  perf_monitor dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_vld(wb_vld), .i_wb_pc(wb_pc), .i_wb_is_ctrl(wb_ctrl), .i_wb_mispred(wb_misp),
    .i_lsu_addr(lsu_addr), .i_lsu_wren(lsu_wren), .i_lsu_rden(lsu_rden),
    .i_lsu_wdata(lsu_wdata), .o_lsu_rdata(o_lsu_rdata), .o_lsu_rvld(o_lsu_rvld),
    .o_insn_vld(o_insn_vld), .o_pc_debug(o_pc_debug), .o_ctrl(o_ctrl), .o_mispred(o_mispred)
  );

  // Model: counters indexed 0=cycle 1=insn 2=ctrl 3=misp
  logic [63:0] m_cnt [4];
  logic [31:0] m_shd [4];
  bit          m_en;
  logic [31:0] e_rdata, e_pc;
  bit          e_rvld, e_ivld, e_ctrl, e_misp;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] off;
    logic [31:0] exp;
    string       nm;
  } rd_vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 64'h0;
      m_shd[i] = 32'h0;
    end
    m_en = 1'b1;
  endtask

  // Advance the model by one edge from the current inputs, then compare.
  task automatic tick();
    logic [31:0] offs;
    bit          hit;
    int          w;
    offs = lsu_addr - BASE;
    hit  = (lsu_addr >= BASE) && (offs < 32'd36) && (lsu_addr[1:0] == 2'b00);
    w    = hit ? int'(offs >> 2) : 0;
    if (!rst) begin
      model_reset();
      e_rvld = 0; e_rdata = 0;
      e_ivld = 0; e_pc = 0; e_ctrl = 0; e_misp = 0;
    end else begin
      e_ivld = wb_vld;
      e_pc   = wb_pc;
      e_ctrl = wb_vld && wb_ctrl;
      e_misp = wb_vld && wb_ctrl && wb_misp;
      e_rvld = 0; e_rdata = 0;
      if (hit && lsu_rden && !lsu_wren) begin
        e_rvld = 1;
        if (w == 0) e_rdata = {31'b0, m_en};
        else if (w % 2 == 1) begin
          e_rdata = m_cnt[(w-1)/2][31:0];
          m_shd[(w-1)/2] = m_cnt[(w-1)/2][63:32];
        end else e_rdata = m_shd[(w-1)/2];
      end
      if (m_en) begin
        m_cnt[0] = m_cnt[0] + 1;
        if (wb_vld) m_cnt[1] = m_cnt[1] + 1;
        if (wb_vld && wb_ctrl) m_cnt[2] = m_cnt[2] + 1;
        if (wb_vld && wb_ctrl && wb_misp) m_cnt[3] = m_cnt[3] + 1;
      end
      if (hit && lsu_wren && w == 0) begin
        if (lsu_wdata[1]) model_reset();
        m_en = lsu_wdata[0];
      end
    end
    @(posedge clk);
    #1;
    chk("rvld",     o_lsu_rvld,  e_rvld);
    chk("rdata",    o_lsu_rdata, e_rdata);
    chk("insn_vld", o_insn_vld,  e_ivld);
    chk("pc_debug", o_pc_debug,  e_pc);
    chk("ctrl",     o_ctrl,      e_ctrl);
    chk("mispred",  o_mispred,   e_misp);
  endtask

  task automatic idle_in();
    wb_vld = 0; wb_ctrl = 0; wb_misp = 0; wb_pc = 0;
    lsu_addr = 0; lsu_wren = 0; lsu_rden = 0; lsu_wdata = 0;
  endtask

  task automatic do_read(input logic [31:0] addr);
    lsu_addr = addr; lsu_rden = 1; lsu_wren = 0;
    tick();
    lsu_rden = 0; lsu_addr = 0;
  endtask

  task automatic do_write(input logic [31:0] off, input logic [31:0] data);
    lsu_addr = BASE + off; lsu_wren = 1; lsu_rden = 0; lsu_wdata = data;
    tick();
    lsu_wren = 0; lsu_addr = 0; lsu_wdata = 0;
  endtask

  task automatic read_expect(input string nm, input logic [31:0] off, input logic [31:0] exp);
    do_read(BASE + off);
    chk(nm, o_lsu_rdata, exp);
  endtask

  rd_vec_t tbl [4];

  initial begin
    tbl[0] = '{off: 32'h0C, exp: 32'd5,  nm: "count_insn"};
    tbl[1] = '{off: 32'h14, exp: 32'd2,  nm: "count_ctrl"};
    tbl[2] = '{off: 32'h1C, exp: 32'd1,  nm: "count_misp"};
    tbl[3] = '{off: 32'h04, exp: 32'd10, nm: "count_cycle"};

    model_reset();
    idle_in();
    rst = 0;
    repeat (3) tick();
    rst = 1;
    chk("rst_rvld", o_lsu_rvld, 0);
    chk("rst_insn_vld", o_insn_vld, 0);
    read_expect("rst_ctrl_reg", 32'h00, 32'h1);

    // Counting: clear, 9 active cycles, then the disabling store is the 10th.
    do_write(32'h00, 32'h3);
    for (int i = 1; i <= 9; i++) begin
      wb_vld  = (i % 2 == 1);
      wb_ctrl = (i == 1 || i == 3);
      wb_misp = (i == 3);
      wb_pc   = 32'h100 + 32'(i * 4);
      tick();
    end
    idle_in();
    do_write(32'h00, 32'h0);
    for (int i = 0; i < 4; i++) begin
      do_read(BASE + tbl[i].off);
      chk(tbl[i].nm, o_lsu_rdata, tbl[i].exp);
    end
    do_write(32'h00, 32'h1);

    // Debug pipe, then a mispredict flag on a non-control instruction.
    wb_vld = 1; wb_pc = 32'h18; wb_ctrl = 1; wb_misp = 1;
    tick();
    chk("dbg_insn_vld", o_insn_vld, 1);
    chk("dbg_pc", o_pc_debug, 32'h18);
    chk("dbg_ctrl", o_ctrl, 1);
    chk("dbg_misp", o_mispred, 1);
    wb_ctrl = 0;
    tick();
    chk("dbg_misp_noctrl", o_mispred, 0);
    idle_in();
    read_expect("misp_unchanged", 32'h1C, 32'd2);

    // Carry snapshot: HI read must return the value latched at LO read.
    force dut.u_cycle.cnt = 64'h0000_0000_FFFF_FFFE;
    #1 release dut.u_cycle.cnt;
    m_cnt[0] = 64'h0000_0000_FFFF_FFFE;
    read_expect("carry_lo", 32'h04, 32'hFFFF_FFFE);
    repeat (3) tick();
    read_expect("carry_hi_snap", 32'h08, 32'h0);
    read_expect("carry_lo2", 32'h04, 32'h0000_0003);
    read_expect("carry_hi2", 32'h08, 32'h1);

    // Wrap from all-ones.
    force dut.u_insn.cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.u_insn.cnt;
    m_cnt[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    wb_vld = 1;
    tick();
    wb_vld = 0;
    read_expect("wrap_lo", 32'h0C, 32'h0);
    read_expect("wrap_hi", 32'h10, 32'h0);

    // Clear colliding with a retiring mispredicted branch.
    wb_vld = 1; wb_ctrl = 1; wb_misp = 1;
    do_write(32'h00, 32'h3);
    idle_in();
    read_expect("clr_cycle", 32'h04, 32'h0);
    read_expect("clr_insn", 32'h0C, 32'h0);
    read_expect("clr_ctrl", 32'h14, 32'h0);
    read_expect("clr_misp", 32'h1C, 32'h0);
    read_expect("clr_en", 32'h00, 32'h1);

    // Misses and load+store collision.
    do_read(BASE + 32'h24);
    chk("miss_0x24", o_lsu_rvld, 0);
    do_read(BASE + 32'h02);
    chk("miss_unaligned", o_lsu_rvld, 0);
    lsu_addr = BASE + 32'h04; lsu_rden = 1; lsu_wren = 1; lsu_wdata = 32'h0;
    tick();
    chk("rd_wr_collide", o_lsu_rvld, 0);
    idle_in();

    // Randomized traffic, including mid-run resets.
    for (int n = 0; n < 600; n++) begin
      int sel, k;
      rst     = ($urandom_range(0, 149) != 0);
      wb_vld  = $urandom_range(0, 1) != 0;
      wb_ctrl = $urandom_range(0, 1) != 0;
      wb_misp = $urandom_range(0, 1) != 0;
      wb_pc   = $urandom;
      sel = $urandom_range(0, 9);
      lsu_rden = (sel >= 4 && sel <= 6) || sel >= 8;
      lsu_wren = (sel == 7 || sel == 8);
      k = $urandom_range(0, 11);
      if (k < 9)       lsu_addr = BASE + 32'(k * 4);
      else if (k == 9) lsu_addr = BASE + 32'h24;
      else if (k == 10) lsu_addr = BASE + 32'($urandom_range(0, 8) * 4 + $urandom_range(1, 3));
      else             lsu_addr = $urandom;
      lsu_wdata = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) != 0) lsu_wdata[0] = 1'b1;
      if ($urandom_range(0, 3) == 0) lsu_wdata[1] = 1'b1;
      tick();
    end
    rst = 1;
    idle_in();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
